video_mode_sequencer: RTL and testbench



---
 rtl/video_mode_sequencer_if.sv | 20 ++
 rtl/video_mode_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_video_mode_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_mode_sequencer_if.sv
// Configuration bus between a host and video_mode_sequencer: shadow register
// writes, commit request, and the busy/error status returned by the sequencer.
interface video_mode_sequencer_if;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_commit;
  logic        cfg_busy;
  logic        cfg_err;

  modport master (
    output cfg_wr, cfg_addr, cfg_wdata, cfg_commit,
    input  cfg_busy, cfg_err
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_wdata, cfg_commit,
    output cfg_busy, cfg_err
  );
endinterface

// File: rtl/video_mode_sequencer.sv
// Raster timing mode controller: shadow/active timing sets, frame-aligned mode
// switch and generator start/stop. Optional vsync watchdog: VMS_VSYNC_WATCHDOG_EN.
module video_mode_sequencer #(
  parameter int          RST_CYCLES  = 4,
  parameter int          WDOG_CYCLES = 2000000,
  parameter logic [15:0] D_HTOTAL    = 16'd1650,
  parameter logic [15:0] D_HACTIVE   = 16'd1280,
  parameter logic [15:0] D_HFP       = 16'd110,
  parameter logic [15:0] D_HSYNC     = 16'd40,
  parameter logic [15:0] D_VTOTAL    = 16'd750,
  parameter logic [15:0] D_VACTIVE   = 16'd720,
  parameter logic [15:0] D_VFP       = 16'd5,
  parameter logic [15:0] D_VSYNC     = 16'd5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         gen_vsync,
  video_mode_sequencer_if.slave        cfg,
  output logic                         mode_switched,
  output logic                         gen_reset_n,
  output logic [15:0]                  htotal,
  output logic [15:0]                  hactive,
  output logic [15:0]                  hfp,
  output logic [15:0]                  hsync_w,
  output logic [15:0]                  vtotal,
  output logic [15:0]                  vactive,
  output logic [15:0]                  vfp,
  output logic [15:0]                  vsync_w
);

  if (RST_CYCLES < 1) begin : g_bad_rst_cycles
    $error("RST_CYCLES must be at least 1");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog_cycles
    $error("WDOG_CYCLES must be at least 1");
  end

  localparam int HoldW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_CYCLES - 1);

  localparam logic [2:0] IdxHtotal  = 3'd0;
  localparam logic [2:0] IdxHactive = 3'd1;
  localparam logic [2:0] IdxHfp     = 3'd2;
  localparam logic [2:0] IdxHsync   = 3'd3;
  localparam logic [2:0] IdxVtotal  = 3'd4;
  localparam logic [2:0] IdxVactive = 3'd5;
  localparam logic [2:0] IdxVfp     = 3'd6;
  localparam logic [2:0] IdxVsync   = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    RUN,
    PENDING,
    STOPPING
  } state_t;

  function automatic logic [15:0] default_timing(input logic [2:0] idx);
    logic [15:0] val;
    case (idx)
      IdxHtotal:  val = D_HTOTAL;
      IdxHactive: val = D_HACTIVE;
      IdxHfp:     val = D_HFP;
      IdxHsync:   val = D_HSYNC;
      IdxVtotal:  val = D_VTOTAL;
      IdxVactive: val = D_VACTIVE;
      IdxVfp:     val = D_VFP;
      default:    val = D_VSYNC;
    endcase
    return val;
  endfunction

  state_t            state;
  logic [15:0]       shadow [8];
  logic [15:0]       active [8];
  logic [HoldW-1:0]  hold_cnt;
  logic              load_pend;
  logic              vs_d;
  logic              busy_q;
  logic              err_q;
  logic              vs_rise;
  logic              waiting;
  logic              wd_fire;
  logic              frame_edge;
  logic              shadow_ok;
  logic [17:0]       h_sum;
  logic [17:0]       v_sum;

  assign vs_rise = gen_vsync & ~vs_d;
  assign waiting = (state == PENDING) || (state == STOPPING);

  // Sums are kept wide enough that no combination of 16-bit fields can wrap.
  assign h_sum = 18'(shadow[IdxHactive]) + 18'(shadow[IdxHfp]) + 18'(shadow[IdxHsync]);
  assign v_sum = 18'(shadow[IdxVactive]) + 18'(shadow[IdxVfp]) + 18'(shadow[IdxVsync]);
  assign shadow_ok = (shadow[IdxHactive] != 16'd0) && (shadow[IdxVactive] != 16'd0) &&
                     (h_sum < 18'(shadow[IdxHtotal])) && (v_sum < 18'(shadow[IdxVtotal]));

`ifdef VMS_VSYNC_WATCHDOG_EN
  logic [31:0] wd_cnt;
  assign wd_fire = waiting && (wd_cnt == 32'(WDOG_CYCLES - 1));
`else
  assign wd_fire = 1'b0;
`endif

  assign frame_edge = vs_rise | wd_fire;

  assign cfg.cfg_busy = busy_q;
  assign cfg.cfg_err  = err_q;

  assign htotal  = active[IdxHtotal];
  assign hactive = active[IdxHactive];
  assign hfp     = active[IdxHfp];
  assign hsync_w = active[IdxHsync];
  assign vtotal  = active[IdxVtotal];
  assign vactive = active[IdxVactive];
  assign vfp     = active[IdxVfp];
  assign vsync_w = active[IdxVsync];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      load_pend     <= 1'b0;
      vs_d          <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      mode_switched <= 1'b0;
      gen_reset_n   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= default_timing(3'(i));
        active[i] <= default_timing(3'(i));
      end
`ifdef VMS_VSYNC_WATCHDOG_EN
      wd_cnt        <= '0;
`endif
    end else begin
      vs_d          <= gen_vsync;
      mode_switched <= 1'b0;

      // The write lands after the case below has already judged the old shadow.
      if (cfg.cfg_wr) begin
        shadow[cfg.cfg_addr] <= cfg.cfg_wdata;
      end

`ifdef VMS_VSYNC_WATCHDOG_EN
      wd_cnt <= (waiting && !frame_edge) ? wd_cnt + 32'd1 : 32'd0;
      if (wd_fire) begin
        err_q <= 1'b1;
      end
`endif

      case (state)
        IDLE: begin
          gen_reset_n <= 1'b0;
          if (cfg.cfg_commit) begin
            if (shadow_ok) begin
              active        <= shadow;
              mode_switched <= 1'b1;
              err_q         <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
          if (enable) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end

        HOLD: begin
          if (hold_cnt == HoldLast) begin
            state       <= RUN;
            gen_reset_n <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        RUN: begin
          gen_reset_n <= 1'b1;
          if (cfg.cfg_commit && shadow_ok) begin
            err_q     <= 1'b0;
            load_pend <= 1'b1;
            busy_q    <= 1'b1;
            state     <= enable ? PENDING : STOPPING;
          end else begin
            if (cfg.cfg_commit) begin
              err_q <= 1'b1;
            end
            if (!enable) begin
              busy_q <= 1'b1;
              state  <= STOPPING;
            end
          end
        end

        PENDING: begin
          if (frame_edge) begin
            active        <= shadow;
            mode_switched <= 1'b1;
            load_pend     <= 1'b0;
            busy_q        <= 1'b0;
            gen_reset_n   <= 1'b0;
            hold_cnt      <= '0;
            state         <= enable ? HOLD : IDLE;
          end else if (!enable) begin
            state <= STOPPING;
`ifdef VMS_VSYNC_WATCHDOG_EN
            wd_cnt <= '0;
`endif
          end
        end

        STOPPING: begin
          if (frame_edge) begin
            if (load_pend) begin
              active        <= shadow;
              mode_switched <= 1'b1;
            end
            load_pend   <= 1'b0;
            busy_q      <= 1'b0;
            gen_reset_n <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          busy_q      <= 1'b0;
          gen_reset_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Self-checking bench for video_mode_sequencer: expected timing sets are queued
// at commit time and compared whenever the sequencer pulses mode_switched.
module tb_video_mode_sequencer;

  localparam int RstCycles  = 4;
  localparam int WdogCycles = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        gen_vsync;
  logic        mode_switched;
  logic        gen_reset_n;
  logic [15:0] htotal, hactive, hfp, hsync_w, vtotal, vactive, vfp, vsync_w;

  video_mode_sequencer_if cfg_bus ();

  video_mode_sequencer #(
    .RST_CYCLES  (RstCycles),
    .WDOG_CYCLES (WdogCycles)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .gen_vsync     (gen_vsync),
    .cfg           (cfg_bus),
    .mode_switched (mode_switched),
    .gen_reset_n   (gen_reset_n),
    .htotal        (htotal),
    .hactive       (hactive),
    .hfp           (hfp),
    .hsync_w       (hsync_w),
    .vtotal        (vtotal),
    .vactive       (vactive),
    .vfp           (vfp),
    .vsync_w       (vsync_w)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [127:0] sb_q[$];
  logic [15:0]  sh [8];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] packModel();
    logic [127:0] p;
    for (int i = 0; i < 8; i++) p[16*i +: 16] = sh[i];
    return p;
  endfunction

  task automatic resetModel();
    sh[0] = 16'd1650; sh[1] = 16'd1280; sh[2] = 16'd110; sh[3] = 16'd40;
    sh[4] = 16'd750;  sh[5] = 16'd720;  sh[6] = 16'd5;   sh[7] = 16'd5;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus cycle; a commit expected to be accepted queues the pre-write set.
  task automatic applyStimulus(input logic wr, input logic [2:0] addr, input logic [15:0] data,
                               input logic commit, input logic expect_load);
    cfg_bus.cfg_wr     = wr;
    cfg_bus.cfg_addr   = addr;
    cfg_bus.cfg_wdata  = data;
    cfg_bus.cfg_commit = commit;
    if (expect_load) sb_q.push_back(packModel());
    if (wr) sh[addr] = data;
    tick();
    cfg_bus.cfg_wr     = 1'b0;
    cfg_bus.cfg_commit = 1'b0;
  endtask

  task automatic measureResetLow(output int low);
    low = 0;
    for (int i = 0; i < 50 && gen_reset_n !== 1'b1; i++) begin
      low++;
      tick();
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && mode_switched === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_switch", 32'd1, 32'd0);
      end else begin
        logic [127:0] exp_set;
        exp_set = sb_q.pop_front();
        checkOutput("sw_htotal",  32'(htotal),  32'(exp_set[15:0]));
        checkOutput("sw_hactive", 32'(hactive), 32'(exp_set[31:16]));
        checkOutput("sw_hfp",     32'(hfp),     32'(exp_set[47:32]));
        checkOutput("sw_hsync",   32'(hsync_w), 32'(exp_set[63:48]));
        checkOutput("sw_vtotal",  32'(vtotal),  32'(exp_set[79:64]));
        checkOutput("sw_vactive", 32'(vactive), 32'(exp_set[95:80]));
        checkOutput("sw_vfp",     32'(vfp),     32'(exp_set[111:96]));
        checkOutput("sw_vsync",   32'(vsync_w), 32'(exp_set[127:112]));
      end
    end
  end

  initial begin
    int low;
    int n;
    reset              = 1'b1;
    enable             = 1'b0;
    gen_vsync          = 1'b0;
    cfg_bus.cfg_wr     = 1'b0;
    cfg_bus.cfg_addr   = 3'd0;
    cfg_bus.cfg_wdata  = 16'd0;
    cfg_bus.cfg_commit = 1'b0;
    resetModel();
    tick(3);
    reset = 1'b0;
    tick();

    $display("[TB] reset defaults");
    checkOutput("rst_htotal",  32'(htotal),  32'd1650);
    checkOutput("rst_hactive", 32'(hactive), 32'd1280);
    checkOutput("rst_hfp",     32'(hfp),     32'd110);
    checkOutput("rst_hsync",   32'(hsync_w), 32'd40);
    checkOutput("rst_vtotal",  32'(vtotal),  32'd750);
    checkOutput("rst_vactive", 32'(vactive), 32'd720);
    checkOutput("rst_vfp",     32'(vfp),     32'd5);
    checkOutput("rst_vsync",   32'(vsync_w), 32'd5);
    checkOutput("rst_gen_reset_n", 32'(gen_reset_n), 32'd0);
    checkOutput("rst_busy", 32'(cfg_bus.cfg_busy), 32'd0);
    checkOutput("rst_err",  32'(cfg_bus.cfg_err),  32'd0);

    $display("[TB] start from idle");
    enable = 1'b1;
    tick();
    measureResetLow(low);
    checkOutput("start_hold_len", 32'(low), 32'(RstCycles));

    $display("[TB] mode switch in run");
    applyStimulus(1'b1, 3'd0, 16'd800, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd1, 16'd640, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd2, 16'd16,  1'b0, 1'b0);
    applyStimulus(1'b1, 3'd3, 16'd96,  1'b0, 1'b0);
    applyStimulus(1'b1, 3'd4, 16'd525, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd5, 16'd480, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd6, 16'd10,  1'b0, 1'b0);
    applyStimulus(1'b1, 3'd7, 16'd2,   1'b0, 1'b0);
    checkOutput("write_no_effect", 32'(hactive), 32'd1280);
    applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b1);
    checkOutput("pend_busy", 32'(cfg_bus.cfg_busy), 32'd1);
    checkOutput("pend_err",  32'(cfg_bus.cfg_err),  32'd0);
    checkOutput("pend_hactive_old", 32'(hactive), 32'd1280);
    tick(3);
    checkOutput("pend_wait_reset_n", 32'(gen_reset_n), 32'd1);
    gen_vsync = 1'b1;
    tick();
    checkOutput("switch_hactive", 32'(hactive), 32'd640);
    checkOutput("switch_busy", 32'(cfg_bus.cfg_busy), 32'd0);
    gen_vsync = 1'b0;
    measureResetLow(low);
    checkOutput("switch_hold_len", 32'(low), 32'(RstCycles));

    $display("[TB] invalid commit in run");
    applyStimulus(1'b1, 3'd0, 16'd1000, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd1, 16'd1280, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
    checkOutput("inv_err", 32'(cfg_bus.cfg_err), 32'd1);
    checkOutput("inv_busy", 32'(cfg_bus.cfg_busy), 32'd0);
    checkOutput("inv_hactive", 32'(hactive), 32'd640);
    gen_vsync = 1'b1;
    tick(2);
    gen_vsync = 1'b0;
    tick(2);
    checkOutput("inv_still_run", 32'(gen_reset_n), 32'd1);
    applyStimulus(1'b1, 3'd0, 16'd1650, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b1);
    checkOutput("valid_clears_err", 32'(cfg_bus.cfg_err), 32'd0);
    checkOutput("valid_busy", 32'(cfg_bus.cfg_busy), 32'd1);
    applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
    checkOutput("pend_commit_ignored", 32'(cfg_bus.cfg_busy), 32'd1);
    gen_vsync = 1'b1;
    tick();
    gen_vsync = 1'b0;
    checkOutput("switch2_hactive", 32'(hactive), 32'd1280);
    measureResetLow(low);
    checkOutput("switch2_hold_len", 32'(low), 32'(RstCycles));

    $display("[TB] stop while pending");
    applyStimulus(1'b1, 3'd1, 16'd720, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b1);
    enable = 1'b0;
    tick();
    checkOutput("stop_busy", 32'(cfg_bus.cfg_busy), 32'd1);
    checkOutput("stop_reset_n", 32'(gen_reset_n), 32'd1);
    enable = 1'b1;
    tick(2);
    enable = 1'b0;
    checkOutput("stop_reenable_busy", 32'(cfg_bus.cfg_busy), 32'd1);
    gen_vsync = 1'b1;
    tick();
    gen_vsync = 1'b0;
    checkOutput("stop_hactive", 32'(hactive), 32'd720);
    checkOutput("stop_gen_reset_n", 32'(gen_reset_n), 32'd0);
    checkOutput("stop_busy_clear", 32'(cfg_bus.cfg_busy), 32'd0);
    tick(6);
    checkOutput("idle_stays_reset", 32'(gen_reset_n), 32'd0);

    $display("[TB] commits in idle");
    applyStimulus(1'b1, 3'd5, 16'd500, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b1);
    checkOutput("idle_vactive", 32'(vactive), 32'd500);
    checkOutput("idle_err", 32'(cfg_bus.cfg_err), 32'd0);
    applyStimulus(1'b1, 3'd1, 16'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
    checkOutput("idle_zero_hactive_err", 32'(cfg_bus.cfg_err), 32'd1);
    checkOutput("idle_zero_hactive_kept", 32'(hactive), 32'd720);
    applyStimulus(1'b1, 3'd1, 16'd640, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd1, 16'd0, 1'b1, 1'b1);
    checkOutput("same_cycle_hactive", 32'(hactive), 32'd640);
    checkOutput("same_cycle_err", 32'(cfg_bus.cfg_err), 32'd0);
    applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b0);
    checkOutput("same_cycle_write_landed", 32'(cfg_bus.cfg_err), 32'd1);

`ifdef VMS_VSYNC_WATCHDOG_EN
    $display("[TB] vsync watchdog");
    applyStimulus(1'b1, 3'd1, 16'd800, 1'b1, 1'b0);
    enable = 1'b1;
    tick();
    measureResetLow(low);
    applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b1);
    n = 0;
    for (int i = 1; i <= 150; i++) begin
      tick();
      n = i;
      if (gen_reset_n === 1'b0) break;
    end
    checkOutput("wdog_latency", 32'(n), 32'(WdogCycles));
    checkOutput("wdog_err", 32'(cfg_bus.cfg_err), 32'd1);
    checkOutput("wdog_hactive", 32'(hactive), 32'd800);
`endif

    $display("[TB] reset mid-operation");
    enable = 1'b1;
    tick();
    measureResetLow(low);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    enable = 1'b0;
    checkOutput("midrst_hactive", 32'(hactive), 32'd1280);
    checkOutput("midrst_vactive", 32'(vactive), 32'd720);
    checkOutput("midrst_gen_reset_n", 32'(gen_reset_n), 32'd0);
    checkOutput("midrst_err", 32'(cfg_bus.cfg_err), 32'd0);
    resetModel();
    tick();
    applyStimulus(1'b0, 3'd0, 16'd0, 1'b1, 1'b1);
    checkOutput("midrst_shadow_default", 32'(cfg_bus.cfg_err), 32'd0);

    tick(3);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
